writeback_scheduler: RTL and testbench

Writer side of the register-file write port: it merges single-cycle ALU results and long-latency results (load/mult/div) into the bank's single write port. It drives `WriteReg`/`WriteData`/`RegWrite` as registered outputs, buffers long-latency results in a small in-order queue, and resolves write-after-write ordering. It also exports a pending-register mask so decode can stall reads of registers with queued writes.

---
 rtl/mips_wb_pkg.sv | 11 +
 rtl/wb_queue.sv | 55 +++++
 rtl/writeback_scheduler.sv | 66 ++++++
 tb/tb_writeback_scheduler.sv | 124 ++++++++++++
 4 files changed

// File: rtl/mips_wb_pkg.sv
// mips_wb_pkg: shared widths and the long-latency queue entry type for the writeback scheduler
package mips_wb_pkg;
  localparam int SIZE = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS = 32;
  typedef struct packed {
    logic                  live;
    logic [REG_ADDR_W-1:0] reg_addr;
    logic [SIZE-1:0]       data;
  } wb_entry_t;
endpackage

// File: rtl/wb_queue.sv
// wb_queue: in-order circular buffer (push/pop/count) with kill-by-register and live pend_mask; ports clock/resetn, push_*, pop, kill_*, head, count, pend_mask
module wb_queue
  import mips_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  push,
  input  logic [REG_ADDR_W-1:0] push_reg,
  input  logic [SIZE-1:0]       push_data,
  input  logic                  pop,
  input  logic                  kill_en,
  input  logic [REG_ADDR_W-1:0] kill_reg,
  output wb_entry_t             head,
  output logic [AW:0]           count,
  output logic [NUM_REGS-1:0]   pend_mask
);
  wb_entry_t       mem_q [DEPTH];
  wb_entry_t       mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
    for (int i = 0; i < DEPTH; i++)
      if (kill_en && mem_q[i].reg_addr == kill_reg) mem_d[i].live = 1'b0;
    // popped slots drop their live bit so pend_mask can OR over every slot
    if (pop) mem_d[rd_ptr_q].live = 1'b0;
    if (push) mem_d[wr_ptr_q] = '{live: 1'b1, reg_addr: push_reg, data: push_data};
  end
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (mem_q[i].live) pend_mask[mem_q[i].reg_addr] = 1'b1;
  end
  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  always_ff @(posedge clock) begin
    if (!resetn) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/writeback_scheduler.sv
// writeback_scheduler: merges ALU (A) and queued long-latency (B) results onto one registered write port; ports a_*, b_*, WriteReg/WriteData/RegWrite, pend_mask, q_count
module writeback_scheduler
  import mips_wb_pkg::*;
#(
  parameter int SIZE  = mips_wb_pkg::SIZE,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  a_valid,
  input  logic [REG_ADDR_W-1:0] a_reg,
  input  logic [SIZE-1:0]       a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [REG_ADDR_W-1:0] b_reg,
  input  logic [SIZE-1:0]       b_data,
  output logic [REG_ADDR_W-1:0] WriteReg,
  output logic [SIZE-1:0]       WriteData,
  output logic                  RegWrite,
  output logic [NUM_REGS-1:0]   pend_mask,
  output logic [AW:0]           q_count
);
  wb_entry_t             head;
  logic                  a_wr, pop, push;
  logic                  reg_write_q, reg_write_d;
  logic [REG_ADDR_W-1:0] write_reg_q, write_reg_d;
  logic [SIZE-1:0]       write_data_q, write_data_d;
  always_comb begin
    a_wr         = a_valid && a_reg != '0;
    pop          = !a_valid && q_count != '0;
    b_ready      = resetn && q_count < (AW+1)'(DEPTH);
    // a B aimed at the register A writes now is already stale: accept and drop it
    push         = b_valid && b_ready && b_reg != '0 && !(a_wr && a_reg == b_reg);
    reg_write_d  = a_wr || (pop && head.live);
    write_reg_d  = a_wr ? a_reg : pop ? head.reg_addr : write_reg_q;
    write_data_d = a_wr ? a_data : pop ? head.data : write_data_q;
  end
  wb_queue #(.DEPTH(DEPTH)) u_queue (
    .clock    (clock),
    .resetn   (resetn),
    .push     (push),
    .push_reg (b_reg),
    .push_data(b_data),
    .pop      (pop),
    .kill_en  (a_wr),
    .kill_reg (a_reg),
    .head     (head),
    .count    (q_count),
    .pend_mask(pend_mask)
  );
  always_ff @(posedge clock) begin
    if (!resetn) begin
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end
  assign RegWrite  = reg_write_q;
  assign WriteReg  = write_reg_q;
  assign WriteData = write_data_q;
endmodule

// File: tb/tb_writeback_scheduler.sv
// tb_writeback_scheduler: directed plus randomized stimulus checked against a queue-based reference model
module tb_writeback_scheduler;
  localparam int DEPTH = 4;
  logic        clock = 1'b0;
  logic        resetn, a_valid, b_valid, b_ready, RegWrite;
  logic [4:0]  a_reg, b_reg, WriteReg;
  logic [31:0] a_data, b_data, WriteData, pend_mask;
  logic [2:0]  q_count;
  int          checks = 0;
  int          errors = 0;
  typedef struct {
    logic        live;
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;
  ent_t        mq[$];
  logic        exp_we = 1'b0;
  logic        exp_known = 1'b0;
  logic        inited = 1'b0;
  logic [4:0]  exp_wr = '0;
  logic [31:0] exp_wd = '0;
  writeback_scheduler #(.DEPTH(DEPTH)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .a_valid  (a_valid),
    .a_reg    (a_reg),
    .a_data   (a_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_reg    (b_reg),
    .b_data   (b_data),
    .WriteReg (WriteReg),
    .WriteData(WriteData),
    .RegWrite (RegWrite),
    .pend_mask(pend_mask),
    .q_count  (q_count)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] model_mask();
    logic [31:0] m = '0;
    foreach (mq[i]) if (mq[i].live) m[mq[i].r] = 1'b1;
    return m;
  endfunction
  task automatic step(input logic rn, input logic av, input logic [4:0] ar, input logic [31:0] ad,
                      input logic bv, input logic [4:0] br, input logic [31:0] bd);
    logic rdy, awr;
    resetn = rn; a_valid = av; a_reg = ar; a_data = ad; b_valid = bv; b_reg = br; b_data = bd;
    @(negedge clock);
    rdy = rn && mq.size() < DEPTH;
    chk("b_ready", 64'(b_ready), 64'(rdy));
    if (inited) begin
      chk("q_count", 64'(q_count), 64'(mq.size()));
      chk("pend_mask", 64'(pend_mask), 64'(model_mask()));
    end
    awr = av && ar != 0;
    if (!rn) begin
      mq.delete();
      exp_we = 0; exp_wr = 0; exp_wd = 0; exp_known = 1;
    end else begin
      if (awr) begin
        foreach (mq[i]) if (mq[i].r == ar) mq[i].live = 1'b0;
        exp_we = 1; exp_wr = ar; exp_wd = ad; exp_known = 1;
      end else if (!av && mq.size() > 0) begin
        ent_t e = mq.pop_front();
        exp_we = e.live; exp_wr = e.r; exp_wd = e.d; exp_known = e.live;
      end else begin
        exp_we = 0; exp_known = 0;
      end
      if (bv && rdy && br != 0 && !(awr && ar == br)) mq.push_back('{1'b1, br, bd});
    end
    @(posedge clock);
    #1;
    if (!rn) inited = 1'b1;
    chk("RegWrite", 64'(RegWrite), 64'(exp_we));
    if (exp_known) begin
      chk("WriteReg", 64'(WriteReg), 64'(exp_wr));
      chk("WriteData", 64'(WriteData), 64'(exp_wd));
    end
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    resetn = 0; a_valid = 0; a_reg = 0; a_data = 0; b_valid = 0; b_reg = 0; b_data = 0;
    for (int i = 0; i < 3; i++) step(0, 1, 5'd3, 32'h5, 1, 5'd4, 32'h6);
    chk("reset_pend", 64'(pend_mask), 64'h0);
    idle(1);
    chk("ready_after_release", 64'(b_ready), 64'h1);
    step(1, 1, 5'd1, 32'h11, 0, 0, 0);
    step(1, 1, 5'd2, 32'h22, 0, 0, 0);
    step(1, 1, 5'd3, 32'h33, 0, 0, 0);
    step(1, 1, 5'd0, 32'h44, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 5'd5, 32'h500 + i, 1, 5'(8 + i), 32'h800 + i);
    step(1, 1, 5'd5, 32'h5ff, 1, 5'd12, 32'hbad);
    chk("fill_count", 64'(q_count), 64'd4);
    chk("fill_mask", 64'(pend_mask), 64'h0000_0F00);
    chk("fill_ready", 64'(b_ready), 64'h0);
    idle(5);
    step(1, 0, 0, 0, 1, 5'd7, 32'hAAAA);
    step(1, 1, 5'd7, 32'hBBBB, 0, 0, 0);
    chk("kill_mask", 64'(pend_mask[7]), 64'h0);
    idle(2);
    step(1, 1, 5'd9, 32'h1, 1, 5'd9, 32'h2);
    chk("conflict_count", 64'(q_count), 64'd0);
    idle(2);
    for (int i = 0; i < 3; i++) step(1, 1, 5'd4, 32'h40 + i, 1, 5'(20 + i), 32'h200 + i);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("midreset_count", 64'(q_count), 64'd0);
    idle(4);
    for (int i = 0; i < 1500; i++)
      step(($urandom_range(199) != 0), ($urandom_range(1) == 1), 5'($urandom_range(15)), $urandom,
           ($urandom_range(2) != 0), 5'($urandom_range(15)), $urandom);
    idle(8);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
